// File: rtl/pattern_detector_pkg.sv
// Shared definitions for the serial pattern detector.
//   MODE_*  : encodings for cfg_overlap
//   fill_w  : width of the history fill counter for a given pattern length
package pattern_detector_pkg;

    localparam logic MODE_NONOVERLAP = 1'b0;
    localparam logic MODE_OVERLAP    = 1'b1;

    // fill counts 0..pat_len inclusive
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter.
//   clk, rst (async, active low), clr (sync clear, wins over inc), inc
//   cnt : current count, stops at all ones
//   sat : registered flag, 1 while cnt is all ones
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);

    logic [W-1:0] cnt_n;

    always_comb begin
        cnt_n = cnt;
        if (clr)
            cnt_n = '0;
        else if (inc && !(&cnt))
            cnt_n = cnt + W'(1);
    end

    // sat is derived from the next count so it lines up with cnt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            cnt <= cnt_n;
            sat <= &cnt_n;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Serial bit-pattern detector with per-bit don't-care mask.
//   clk, rst (async, active low), clr (sync clear, wins over in_valid)
//   In, in_valid             : serial stream and its qualifier
//   cfg_pattern, cfg_mask    : target pattern ([PAT_LEN-1] oldest) and compare mask
//   cfg_overlap              : 1 = overlapping, 0 = non-overlapping detection
//   Out                      : registered one-cycle match pulse
//   match_cnt, cnt_sat       : saturating match count and its saturation flag
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               In,
    input  logic               in_valid,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic [PAT_LEN-1:0] cfg_mask,
    input  logic               cfg_overlap,
    output logic               Out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int            FW   = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] hist, hist_n;
    logic [FW-1:0]      fill, fill_inc, fill_n;
    logic               hit;

    always_comb begin
        hist_n   = hist;
        fill_inc = fill;
        fill_n   = fill;
        hit      = 1'b0;
        if (in_valid) begin
            hist_n   = {hist[PAT_LEN-2:0], In};
            fill_inc = (fill == FULL) ? FULL : fill + FW'(1);
            fill_n   = fill_inc;
            // a full window is required even if the mask ignores every bit
            hit = (fill_inc == FULL) &&
                  (((hist_n ^ cfg_pattern) & cfg_mask) == '0);
            // non-overlap: the matched bits may not be reused
            if (hit && cfg_overlap == MODE_NONOVERLAP)
                fill_n = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
            fill <= '0;
            Out  <= 1'b0;
        end else if (clr) begin
            hist <= '0;
            fill <= '0;
            Out  <= 1'b0;
        end else begin
            hist <= hist_n;
            fill <= fill_n;
            Out  <= hit;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (hit),
        .cnt (match_cnt),
        .sat (cnt_sat)
    );

endmodule
